pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the NeuroRISC fetch stage, generalising the fixed 32-bit PC register. It holds the architectural PC and adds a boot handshake, a stall hold, prioritised trap/redirect handling with misalignment detection and exception PC capture, and a circular return-address stack (RAS) for call/return prediction. It sits between the branch/jump resolution logic and the instruction-fetch address port.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: boot handshake, stall hold,
// prioritised trap/redirect with misalignment trapping, and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap_req,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_rel,
  output logic [XLEN-1:0] epc,
  output logic            misalign,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_q,    state_d;
  logic [XLEN-1:0]  pc_q,       pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [XLEN-1:0]  epc_q,      epc_d;
  logic             misalign_q, misalign_d;
  logic [PTR_W-1:0] ptr_q,      ptr_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [XLEN-1:0]  ras_d [RAS_DEPTH];
  logic [XLEN-1:0]  pc_inc;

  assign pc_inc = pc_q + XLEN'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (trap_req) begin
          pc_d  = TRAP_VECTOR;
          epc_d = pc_q;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          pc_d       = TRAP_VECTOR;
          epc_d      = pc_q;
          misalign_d = 1'b1;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
          // Pointer always addresses the top; a push on a full stack overwrites the oldest slot.
          if (call && ret) begin
            ras_d[ptr_q] = pc_inc;
            if (cnt_q == '0) cnt_d = CNT_W'(1);
          end else if (call) begin
            ptr_d        = ptr_q + PTR_W'(1);
            ras_d[ptr_d] = pc_inc;
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
          end else if (ret && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      epc_q      <= '0;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
    end
  end

  assign pc_out    = pc_q;
  assign pc_valid  = pc_valid_q;
  assign pc_plus4  = pc_inc;
  assign pc_rel    = pc_q + imm;
  assign epc       = epc_q;
  assign misalign  = misalign_q;
  assign ras_valid = (cnt_q != '0);
  assign ras_top   = (cnt_q != '0) ? ras_q[ptr_q] : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset/boot, stall vs redirect, misalignment, trap
// priority, RAS overflow/underflow and combined call+ret, PC wrap and pc_rel.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call;
  logic        ret;
  logic        trap_req;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_plus4;
  logic [31:0] pc_rel;
  logic [31:0] epc;
  logic        misalign;
  logic [31:0] ras_top;
  logic        ras_valid;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .XLEN        (32),
    .RESET_VECTOR(32'h40),
    .TRAP_VECTOR (32'h100),
    .RAS_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .call           (call),
    .ret            (ret),
    .trap_req       (trap_req),
    .imm            (imm),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .pc_plus4       (pc_plus4),
    .pc_rel         (pc_rel),
    .epc            (epc),
    .misalign       (misalign),
    .ras_top        (ras_top),
    .ras_valid      (ras_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic c, input logic r);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    call            = c;
    ret             = r;
    step();
    redirect_valid  = 1'b0;
    call            = 1'b0;
    ret             = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; imm = 32'h10;
    step(); step();
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL rst_pc: got %h want %h", pc_out, 32'h40); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc: got %h want 0", epc); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign); end
    checks++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin errors++; $display("FAIL rst_ras: got %b/%h want 0/0", ras_valid, ras_top); end
    checks++; if (pc_plus4 !== 32'h44) begin errors++; $display("FAIL rst_plus4: got %h want 44", pc_plus4); end
    checks++; if (pc_rel !== 32'h50) begin errors++; $display("FAIL rst_rel: got %h want 50", pc_rel); end
    reset = 1'b0;
    step();
    checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h40) begin errors++; $display("FAIL boot: got %b/%h want 1/40", pc_valid, pc_out); end
    step();
    checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL run1: got %h want 44", pc_out); end
    step();
    checks++; if (pc_out !== 32'h48) begin errors++; $display("FAIL run2: got %h want 48", pc_out); end
  endtask

  task automatic test_boot_ignores_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0; trap_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    step();
    trap_req = 1'b0; redirect_valid = 1'b0;
    checks++; if (pc_out !== 32'h40 || epc !== 32'h0) begin errors++; $display("FAIL boot_ignore: got %h/%h want 40/0", pc_out, epc); end
  endtask

  task automatic test_stall_vs_redirect();
    redirect(32'h100, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL stall_%0d: got %h want 100", i, pc_out); end
    end
    redirect(32'h200, 1'b0, 1'b0);
    checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL stall_redirect: got %h want 200", pc_out); end
    stall = 1'b0;
    call = 1'b1; ret = 1'b0;
    step();
    call = 1'b0;
    checks++; if (pc_out !== 32'h204 || ras_valid !== 1'b0) begin errors++; $display("FAIL call_no_redirect: got %h/%b want 204/0", pc_out, ras_valid); end
  endtask

  task automatic test_misalign();
    redirect(32'h80, 1'b0, 1'b0);
    redirect(32'h102, 1'b1, 1'b0);
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL mis_pc: got %h want 100", pc_out); end
    checks++; if (epc !== 32'h80) begin errors++; $display("FAIL mis_epc: got %h want 80", epc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misalign); end
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL mis_ras: got %b want 0", ras_valid); end
    step();
    checks++; if (misalign !== 1'b0 || pc_out !== 32'h104) begin errors++; $display("FAIL mis_clear: got %b/%h want 0/104", misalign, pc_out); end
  endtask

  task automatic test_trap_priority();
    redirect(32'h60, 1'b0, 1'b0);
    redirect(32'h50, 1'b1, 1'b0);
    checks++; if (ras_top !== 32'h64 || ras_valid !== 1'b1) begin errors++; $display("FAIL trap_pre_ras: got %h/%b want 64/1", ras_top, ras_valid); end
    trap_req = 1'b1; stall = 1'b1;
    redirect(32'h300, 1'b1, 1'b0);
    trap_req = 1'b0; stall = 1'b0;
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL trap_pc: got %h want 100", pc_out); end
    checks++; if (epc !== 32'h50) begin errors++; $display("FAIL trap_epc: got %h want 50", epc); end
    checks++; if (ras_top !== 32'h64 || ras_valid !== 1'b1) begin errors++; $display("FAIL trap_ras: got %h/%b want 64/1", ras_top, ras_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL trap_misalign: got %b want 0", misalign); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_top [4];
    do_reset();
    redirect(32'h10, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      redirect(32'(16 * (k + 1)), 1'b1, 1'b0);
      checks++; if (ras_top !== 32'(16 * k + 4) || ras_valid !== 1'b1) begin errors++; $display("FAIL push_%0d: got %h/%b want %h/1", k, ras_top, ras_valid, 32'(16 * k + 4)); end
    end
    exp_top[0] = 32'h44; exp_top[1] = 32'h34; exp_top[2] = 32'h24; exp_top[3] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      redirect(32'h200, 1'b0, 1'b1);
      checks++; if (ras_top !== exp_top[k] || ras_valid !== (k != 3)) begin errors++; $display("FAIL pop_%0d: got %h/%b want %h/%b", k, ras_top, ras_valid, exp_top[k], k != 3); end
    end
    redirect(32'h200, 1'b0, 1'b1);
    checks++; if (ras_top !== 32'h0 || ras_valid !== 1'b0 || pc_out !== 32'h200) begin errors++; $display("FAIL pop_empty: got %h/%b/%h want 0/0/200", ras_top, ras_valid, pc_out); end
    redirect(32'h300, 1'b1, 1'b1);
    checks++; if (ras_top !== 32'h204 || ras_valid !== 1'b1) begin errors++; $display("FAIL callret_empty: got %h/%b want 204/1", ras_top, ras_valid); end
    redirect(32'h400, 1'b0, 1'b1);
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL callret_cnt1: got %b want 0", ras_valid); end
    redirect(32'h500, 1'b1, 1'b0);
    redirect(32'h600, 1'b1, 1'b1);
    checks++; if (ras_top !== 32'h504 || ras_valid !== 1'b1) begin errors++; $display("FAIL callret_replace: got %h/%b want 504/1", ras_top, ras_valid); end
    redirect(32'h700, 1'b0, 1'b1);
    checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL callret_keep: got %b want 0", ras_valid); end
  endtask

  task automatic test_wrap_and_rel();
    redirect(32'hFFFF_FFFC, 1'b0, 1'b0);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
    step();
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
    stall = 1'b1;
    redirect(32'h10, 1'b0, 1'b0);
    imm = 32'hFFFF_FFF8;
    #1;
    checks++; if (pc_rel !== 32'h8) begin errors++; $display("FAIL rel_neg: got %h want 8", pc_rel); end
    imm = 32'h20;
    #1;
    checks++; if (pc_rel !== 32'h30) begin errors++; $display("FAIL rel_pos: got %h want 30", pc_rel); end
    stall = 1'b0;
  endtask

  task automatic test_async_reset();
    redirect(32'h60, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    checks++; if (pc_out !== 32'h40 || pc_valid !== 1'b0 || epc !== 32'h0 || ras_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h/%b/%h/%b want 40/0/0/0", pc_out, pc_valid, epc, ras_valid);
    end
    step();
    reset = 1'b0;
    step();
    checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h40) begin errors++; $display("FAIL async_reboot: got %b/%h want 1/40", pc_valid, pc_out); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    call = 1'b0; ret = 1'b0; trap_req = 1'b0; imm = '0;
    test_reset();
    test_boot_ignores_inputs();
    test_stall_vs_redirect();
    test_misalign();
    test_trap_priority();
    test_ras();
    test_wrap_and_rel();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
